softmax_stream: RTL

SOFTMAX_STREAM -- requirements
Module: softmax_stream

---
 rtl/softmax_stream.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/softmax_stream.sv
// rtl/softmax_stream.sv - streaming softmax / argmax over one frame of N_CLASS fixed-point scores
//
// Accepts N_CLASS signed scores per frame, then emits either N_CLASS softmax
// probabilities (Q0.OUT_W) or a single argmax beat.
//
// Ports
//   clk          in   1          sole clock, rising edge
//   resetn       in   1          asynchronous reset, ACTIVE HIGH (1 = reset)
//   mode_argmax  in   1          sampled with the first beat of a frame
//   in_valid     in   1          input beat valid
//   in_ready     out  1          block accepts an input beat (IDLE/LOAD)
//   in_data      in   IN_W       class score, class index = beat order
//   out_valid    out  1          output beat valid
//   out_ready    in   1          downstream accepts output beat
//   out_data     out  OUT_W      probability of class out_idx
//   out_idx      out  clog2(N)   class index of current output beat
//   out_last     out  1          final beat of an output frame
//   argmax_idx   out  clog2(N)   index of the maximum of the last completed frame
//   busy         out  1          high whenever not IDLE
module softmax_stream #(
    parameter int N_CLASS  = 10,
    parameter int IN_W     = 16,
    parameter int IN_FRAC  = 8,
    parameter int OUT_W    = 16,
    parameter int LUT_AW   = 8,
    parameter int LUT_FRAC = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       mode_argmax,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(N_CLASS)-1:0] out_idx,
    output logic                       out_last,
    output logic [$clog2(N_CLASS)-1:0] argmax_idx,
    output logic                       busy
);

    localparam int CW    = $clog2(N_CLASS);
    localparam int SUM_W = OUT_W + CW;
    localparam int BW    = $clog2(OUT_W + 1);
    localparam int SHIFT = IN_FRAC - LUT_FRAC;
    localparam int LUT_N = 2 ** LUT_AW;

    localparam logic [CW-1:0] LAST_IDX = CW'(N_CLASS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(OUT_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXP,
        S_DIV,
        S_OUT
    } state_t;

    // exp table entry: round((2^OUT_W - 1) * exp(-k / 2^LUT_FRAC)),
    // evaluated at elaboration time only.
    function automatic logic [OUT_W-1:0] lut_value(input int k);
        real scale;
        real v;
        scale = (2.0 ** OUT_W) - 1.0;
        v     = scale * $exp(-real'(k) / (2.0 ** LUT_FRAC));
        return OUT_W'($rtoi(v + 0.5));
    endfunction

    logic [OUT_W-1:0] lut_rom [LUT_N];

    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign lut_rom[k] = lut_value(k);
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [CW-1:0]    cls_q;        // beat count in LOAD, class index in EXP/DIV
    logic [BW-1:0]    bit_q;        // divider step within one class
    logic [IN_W-1:0]  max_q;
    logic [CW-1:0]    max_idx_q;
    logic [CW-1:0]    argmax_q;
    logic             mode_q;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] rem_q;
    logic [OUT_W-1:0] quot_q;

    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic [CW-1:0]    out_idx_q;
    logic             out_last_q;

    logic [IN_W-1:0]  xbuf_q [N_CLASS];
    // Holds e_i after EXP; each entry is overwritten by q_i once its division ends.
    logic [OUT_W-1:0] ebuf_q [N_CLASS];

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic          in_fire;
    logic          out_fire;
    logic          first_beat;
    logic          new_max;
    logic          frame_argmax;
    logic [CW-1:0] load_idx;
    logic [CW-1:0] max_idx_d;
    logic [CW-1:0] out_idx_nxt;

    assign in_ready     = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign in_fire      = in_valid && in_ready;
    assign out_fire     = out_valid_q && out_ready;
    assign first_beat   = (state_q == S_IDLE);
    assign load_idx     = first_beat ? '0 : cls_q;
    // Strict compare so that ties keep the lowest index.
    assign new_max      = first_beat || ($signed(in_data) > $signed(max_q));
    assign max_idx_d    = new_max ? load_idx : max_idx_q;
    assign frame_argmax = first_beat ? mode_argmax : mode_q;
    assign out_idx_nxt  = out_idx_q + 1'b1;

    // ------------------------------------------------------------------
    // Exp path: d = max - x_i is never negative, so it is indexed unsigned.
    // ------------------------------------------------------------------
    logic [IN_W-1:0]      cur_x;
    logic signed [IN_W:0] diff;
    logic [IN_W:0]        diff_u;
    logic [IN_W:0]        addr_full;
    logic                 addr_ok;
    logic [OUT_W-1:0]     e_val;

    assign cur_x     = xbuf_q[cls_q];
    assign diff      = $signed({max_q[IN_W-1], max_q}) - $signed({cur_x[IN_W-1], cur_x});
    assign diff_u    = diff;
    assign addr_full = diff_u >> SHIFT;
    assign addr_ok   = (addr_full >> LUT_AW) == '0;
    assign e_val     = addr_ok ? lut_rom[addr_full[LUT_AW-1:0]] : '0;

    // ------------------------------------------------------------------
    // Restoring divider: q = floor(e * 2^OUT_W / sum), one quotient bit per
    // cycle, MSB first. The dividend's low OUT_W bits are zero, so after the
    // first step the partial remainder simply shifts in zeros.
    // ------------------------------------------------------------------
    logic [SUM_W:0]   trial;
    logic [SUM_W-1:0] trial_sub;
    logic             take;
    logic [SUM_W-1:0] rem_d;
    logic [OUT_W:0]   quot_d;
    logic [OUT_W-1:0] q_sat;
    logic             div_last;

    assign trial     = (bit_q == '0) ? (SUM_W+1)'(ebuf_q[cls_q]) : {rem_q, 1'b0};
    assign take      = trial >= {1'b0, sum_q};
    // trial - sum < sum whenever taken, so the narrow subtraction is exact.
    assign trial_sub = trial[SUM_W-1:0] - sum_q;
    assign rem_d     = take ? trial_sub : trial[SUM_W-1:0];
    // quot_q keeps only OUT_W bits; on the final step its MSB is the 2^OUT_W bit.
    assign quot_d    = {quot_q, take};
    assign q_sat     = quot_d[OUT_W] ? '1 : quot_d[OUT_W-1:0];
    assign div_last  = (bit_q == LAST_BIT);

    // ------------------------------------------------------------------
    // Frame buffers (no reset needed: always written before being read)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (in_fire) begin
            xbuf_q[load_idx] <= in_data;
        end
        if (state_q == S_EXP) begin
            ebuf_q[cls_q] <= e_val;
        end else if ((state_q == S_DIV) && div_last) begin
            ebuf_q[cls_q] <= q_sat;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q     <= S_IDLE;
            cls_q       <= '0;
            bit_q       <= '0;
            max_q       <= '0;
            max_idx_q   <= '0;
            argmax_q    <= '0;
            mode_q      <= 1'b0;
            sum_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (in_fire) begin
                        if (first_beat) begin
                            mode_q <= mode_argmax;
                        end
                        if (new_max) begin
                            max_q <= in_data;
                        end
                        max_idx_q <= max_idx_d;
                        if (load_idx == LAST_IDX) begin
                            argmax_q <= max_idx_d;
                            cls_q    <= '0;
                            sum_q    <= '0;
                            if (frame_argmax) begin
                                state_q     <= S_OUT;
                                out_valid_q <= 1'b1;
                                out_idx_q   <= max_idx_d;
                                out_data_q  <= '1;
                                out_last_q  <= 1'b1;
                            end else begin
                                state_q <= S_EXP;
                            end
                        end else begin
                            cls_q   <= load_idx + 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                end

                S_EXP: begin
                    sum_q <= sum_q + SUM_W'(e_val);
                    if (cls_q == LAST_IDX) begin
                        cls_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_DIV;
                    end else begin
                        cls_q <= cls_q + 1'b1;
                    end
                end

                S_DIV: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d[OUT_W-1:0];
                    if (div_last) begin
                        bit_q <= '0;
                        if (cls_q == LAST_IDX) begin
                            // q_0 was written back long ago, so beat 0 is ready now.
                            state_q     <= S_OUT;
                            cls_q       <= '0;
                            out_valid_q <= 1'b1;
                            out_idx_q   <= '0;
                            out_data_q  <= ebuf_q[0];
                            out_last_q  <= 1'b0;
                        end else begin
                            cls_q <= cls_q + 1'b1;
                        end
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end

                S_OUT: begin
                    if (out_fire) begin
                        if (out_last_q) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_idx_q   <= '0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_idx_q  <= out_idx_nxt;
                            out_data_q <= ebuf_q[out_idx_nxt];
                            out_last_q <= (out_idx_nxt == LAST_IDX);
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_idx    = out_idx_q;
    assign out_last   = out_last_q;
    assign argmax_idx = argmax_q;
    assign busy       = (state_q != S_IDLE);

endmodule
